// File: rtl/pipe_exec_ctrl.sv
// Pipeline execution controller: sequences continuous and stepwise runs,
// drains ID/EX/MEM/WB after EOF and counts executed cycles or steps.
module pipe_exec_ctrl #(
    parameter int unsigned NB_CYCLES    = 16,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned NB_DRAIN     = 3
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_start_cont,
    input  logic                 i_start_step,
    input  logic                 i_step_req,
    input  logic                 i_eof_flag,
    input  logic                 i_halt,
    output logic [1:0]           o_pipeline_mode,
    output logic                 o_execute_instruct,
    output logic                 o_pc_enable,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [NB_CYCLES-1:0] o_cycle_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN_CONT,
        ST_STEP_WAIT,
        ST_STEP_EXEC,
        ST_DRAIN_CONT,
        ST_DRAIN_STEP,
        ST_DONE
    } state_e;

    state_e                state_q, state_d;
    logic                  step_q, step_d;
    logic                  start_cont_q, start_cont_d;
    logic                  start_step_q, start_step_d;
    logic                  exec_q, exec_d;
    logic [NB_CYCLES-1:0]  cnt_q, cnt_d;
    logic [NB_DRAIN-1:0]   drain_q, drain_d;

    logic step_rise;
    logic start_cont_rise;
    logic start_step_rise;
    logic drain_pulse;
    logic start_run;
    logic cnt_inc;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            step_q       <= 1'b0;
            start_cont_q <= 1'b0;
            start_step_q <= 1'b0;
            exec_q       <= 1'b0;
            cnt_q        <= '0;
            drain_q      <= '0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            start_cont_q <= start_cont_d;
            start_step_q <= start_step_d;
            exec_q       <= exec_d;
            cnt_q        <= cnt_d;
            drain_q      <= drain_d;
        end
    end

    always_comb begin
        step_rise       = i_step_req & ~step_q;
        start_cont_rise = i_start_cont & ~start_cont_q;
        start_step_rise = i_start_step & ~start_step_q;

        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start_cont)      state_d = ST_RUN_CONT;
                else if (i_start_step) state_d = ST_STEP_WAIT;
            end
            ST_RUN_CONT: begin
                if (i_eof_flag) state_d = ST_DRAIN_CONT;
            end
            ST_DRAIN_CONT: begin
                if (drain_q <= NB_DRAIN'(1)) state_d = ST_DONE;
            end
            ST_STEP_WAIT: begin
                if (step_rise) state_d = ST_STEP_EXEC;
            end
            ST_STEP_EXEC: begin
                state_d = i_eof_flag ? ST_DRAIN_STEP : ST_STEP_WAIT;
            end
            ST_DRAIN_STEP: begin
                if (drain_q == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (start_cont_rise)      state_d = ST_RUN_CONT;
                else if (start_step_rise) state_d = ST_STEP_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase
        if (i_halt) state_d = ST_IDLE;
    end

    // Rises arriving while STEP_EXEC is active are consumed by step_q and lost.
    always_comb begin
        step_d       = i_step_req;
        start_cont_d = i_start_cont;
        start_step_d = i_start_step;

        drain_pulse = (state_q == ST_DRAIN_STEP) && (drain_q != '0) && step_rise && !i_halt;
        start_run   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) &&
                      ((state_d == ST_RUN_CONT) || (state_d == ST_STEP_WAIT));
        cnt_inc     = (!i_halt && ((state_q == ST_RUN_CONT) || (state_q == ST_DRAIN_CONT))) ||
                      ((state_q == ST_STEP_WAIT) && (state_d == ST_STEP_EXEC)) ||
                      drain_pulse;

        cnt_d = cnt_q;
        if (start_run)                cnt_d = '0;
        else if (cnt_inc && cnt_q != '1) cnt_d = cnt_q + NB_CYCLES'(1);

        drain_d = drain_q;
        if (start_run)
            drain_d = NB_DRAIN'(DRAIN_CYCLES);
        else if (((state_q == ST_DRAIN_CONT) && !i_halt && (drain_q != '0)) || drain_pulse)
            drain_d = drain_q - NB_DRAIN'(1);

        exec_d = (state_d == ST_STEP_EXEC) || drain_pulse;
    end

    always_comb begin
        o_pipeline_mode = 2'b00;
        o_pc_enable     = 1'b0;
        o_busy          = 1'b1;
        o_done          = 1'b0;
        unique case (state_q)
            ST_IDLE:       o_busy = 1'b0;
            ST_RUN_CONT: begin
                o_pipeline_mode = 2'b01;
                o_pc_enable     = 1'b1;
            end
            ST_DRAIN_CONT: o_pipeline_mode = 2'b01;
            ST_STEP_WAIT:  o_pipeline_mode = 2'b11;
            ST_STEP_EXEC: begin
                o_pipeline_mode = 2'b11;
                o_pc_enable     = 1'b1;
            end
            ST_DRAIN_STEP: o_pipeline_mode = 2'b11;
            ST_DONE: begin
                o_busy = 1'b0;
                o_done = 1'b1;
            end
            default:       o_busy = 1'b0;
        endcase
        o_execute_instruct = exec_q;
        o_cycle_count      = cnt_q;
    end

endmodule

// File: tb/tb_pipe_exec_ctrl.sv
// Scoreboard bench for pipe_exec_ctrl: stimulus queues expected pulses/DONE
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_pipe_exec_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start_cont;
    logic        start_step;
    logic        step_req;
    logic        eof;
    logic        halt;
    logic [1:0]  mode;
    logic        exec;
    logic        pc_en;
    logic        busy;
    logic        done;
    logic [15:0] cnt;
    logic [1:0]  s_mode;
    logic        s_exec;
    logic        s_pc_en;
    logic        s_busy;
    logic        s_done;
    logic [3:0]  s_cnt;

    typedef struct {
        bit          is_done;
        int unsigned cnt;
        bit          pc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned mode01_cycles = 0;
    int unsigned pc_cycles = 0;

    pipe_exec_ctrl #(.NB_CYCLES(16), .DRAIN_CYCLES(4), .NB_DRAIN(3)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_start_cont(start_cont),
        .i_start_step(start_step), .i_step_req(step_req), .i_eof_flag(eof),
        .i_halt(halt), .o_pipeline_mode(mode), .o_execute_instruct(exec),
        .o_pc_enable(pc_en), .o_busy(busy), .o_done(done), .o_cycle_count(cnt)
    );

    pipe_exec_ctrl #(.NB_CYCLES(4), .DRAIN_CYCLES(4), .NB_DRAIN(3)) dut_sat (
        .i_clk(clk), .i_reset_n(rst_n), .i_start_cont(start_cont),
        .i_start_step(start_step), .i_step_req(step_req), .i_eof_flag(eof),
        .i_halt(halt), .o_pipeline_mode(s_mode), .o_execute_instruct(s_exec),
        .o_pc_enable(s_pc_en), .o_busy(s_busy), .o_done(s_done), .o_cycle_count(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pulse(input int unsigned c, input bit pc);
        exp_t e;
        e.is_done = 1'b0; e.cnt = c; e.pc = pc;
        exp_q.push_back(e);
    endtask

    task automatic push_done(input int unsigned c);
        exp_t e;
        e.is_done = 1'b1; e.cnt = c; e.pc = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int unsigned budget);
        int unsigned n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk("done_timeout", done, 1);
    endtask

    task automatic do_step(input bit with_eof);
        step_req = 1'b1;
        eof      = with_eof;
        tick();
        step_req = 1'b0;
        tick();
        eof = 1'b0;
        tick();
    endtask

    // Monitor: pops one expectation per execute pulse or DONE entry.
    initial begin
        bit exec_prev = 1'b0;
        bit done_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exec_prev = 1'b0;
                done_prev = 1'b0;
            end else begin
                if (exec) begin
                    chk("exec_width", exec_prev, 0);
                    if (exp_q.size() == 0 || exp_q[0].is_done) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse: got pulse at count %0d expected none", cnt);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pulse_count", cnt, e.cnt);
                        chk("pulse_pc_en", pc_en, e.pc);
                        chk("pulse_mode", mode, 2'b11);
                    end
                end
                if (done && !done_prev) begin
                    if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done at count %0d expected none", cnt);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_count", cnt, e.cnt);
                        chk("done_mode", mode, 2'b00);
                    end
                end
                if (mode == 2'b01) mode01_cycles++;
                if (pc_en) pc_cycles++;
                exec_prev = exec;
                done_prev = done;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; start_cont = 1'b0; start_step = 1'b0;
        step_req = 1'b0; eof = 1'b0; halt = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mode", mode, 0);
        chk("rst_exec", exec, 0);
        chk("rst_pc_en", pc_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Continuous run: 10 RUN_CONT cycles then 4 drain cycles.
        push_done(14);
        start_cont = 1'b1;
        tick();
        start_cont = 1'b0;
        mode01_cycles = 0;
        pc_cycles = 0;
        chk("cont_mode", mode, 2'b01);
        chk("cont_count_clear", cnt, 0);
        repeat (9) tick();
        eof = 1'b1;
        tick();
        eof = 1'b0;
        chk("cont_pc_drop", pc_en, 0);
        wait_done(20);
        chk("cont_mode01_cycles", mode01_cycles, 14);
        chk("cont_pc_cycles", pc_cycles, 10);
        repeat (3) tick();
        chk("done_hold_count", cnt, 14);
        chk("done_hold_busy", busy, 0);

        // Step run restarted from DONE: 3 steps (EOF on 3rd) + 4 drain steps.
        start_step = 1'b1;
        tick();
        start_step = 1'b0;
        chk("step_mode", mode, 2'b11);
        chk("step_count_clear", cnt, 0);
        for (int i = 1; i <= 3; i++) push_pulse(i, 1'b1);
        for (int i = 4; i <= 7; i++) push_pulse(i, 1'b0);
        push_done(7);
        do_step(1'b0);
        do_step(1'b0);
        do_step(1'b1);
        repeat (4) do_step(1'b0);
        wait_done(10);

        // Held step request gives a single pulse.
        start_step = 1'b1;
        tick();
        start_step = 1'b0;
        push_pulse(1, 1'b1);
        step_req = 1'b1;
        repeat (20) tick();
        step_req = 1'b0;
        tick();
        chk("held_step_count", cnt, 1);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt_mode", mode, 0);

        // Both starts together: continuous wins.
        start_cont = 1'b1;
        start_step = 1'b1;
        tick();
        start_cont = 1'b0;
        start_step = 1'b0;
        chk("both_start_mode", mode, 2'b01);
        halt = 1'b1;
        tick();
        halt = 1'b0;

        // Halt in DRAIN_CONT, then reset during STEP_EXEC.
        start_cont = 1'b1;
        tick();
        start_cont = 1'b0;
        repeat (3) tick();
        eof = 1'b1;
        tick();
        eof = 1'b0;
        chk("drain_mode", mode, 2'b01);
        chk("drain_pc_en", pc_en, 0);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt_drain_mode", mode, 0);
        chk("halt_drain_busy", busy, 0);
        chk("halt_drain_count", cnt, 4);
        repeat (2) tick();
        chk("idle_hold_count", cnt, 4);
        start_step = 1'b1;
        tick();
        start_step = 1'b0;
        push_pulse(1, 1'b1);
        step_req = 1'b1;
        tick();
        #5;
        rst_n = 1'b0;
        #1;
        chk("async_rst_exec", exec, 0);
        chk("async_rst_mode", mode, 0);
        chk("async_rst_pc_en", pc_en, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_count", cnt, 0);
        step_req = 1'b0;
        tick();
        chk("rst_held_exec", exec, 0);
        rst_n = 1'b1;
        start_cont = 1'b1;
        tick();
        start_cont = 1'b0;
        chk("first_edge_mode", mode, 2'b01);
        halt = 1'b1;
        tick();
        halt = 1'b0;

        // Saturation: 20 RUN_CONT cycles + 4 drain on both widths.
        push_done(24);
        start_cont = 1'b1;
        tick();
        start_cont = 1'b0;
        repeat (19) tick();
        eof = 1'b1;
        tick();
        eof = 1'b0;
        wait_done(20);
        chk("sat_done", s_done, 1);
        chk("sat_count", s_cnt, 15);
        tick();
        chk("sat_hold", s_cnt, 15);

        tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
